// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Round-robin arbiter that lets NUM_REQ byte producers share one UART
// transmitter. A one-hot FSM (IDLE -> SEND -> WAIT) accepts one byte. It pulses
// tx_send for that byte, then holds the byte until the transmitter returns
// tx_done. The requester searched first is the one after the last requester
// served.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to bound WAIT to
// TIMEOUT_CYCLES clocks. On expiry timeout_err pulses and the arbiter returns
// to IDLE. Without the macro no counter exists and timeout_err is tied low.
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst          asynchronous, active-low reset
//   req_valid    [NUM_REQ]    requester i offers a byte
//   req_data     [NUM_REQ*8]  byte of requester i in bits [8i+7:8i]
//   req_ready    [NUM_REQ]    combinational one-hot accept (IDLE only)
//   tx_send      one-cycle start pulse to the transmitter
//   tx_data      byte being transmitted, stable from tx_send to tx_done
//   tx_done      one-cycle completion pulse from the transmitter
//   grant_id     index of the requester owning the transmitter
//   busy         high in SEND and WAIT
//   timeout_err  one-cycle pulse when WAIT is aborted
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SEND = 3'b010,
        WAIT = 3'b100
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [GW-1:0] last_grant_r;
    logic [GW-1:0] grant_r;
    logic [7:0]    tx_data_r;
    logic          tx_send_r;
    logic          busy_r;
    logic [GW-1:0] win_s;
    logic [7:0]    win_data_s;
    logic          found_s;
    logic [GW:0]   sum_s;
    logic [GW-1:0] idx_s;
    logic          any_valid_s;
    logic          transfer_s;
    logic          done_s;
    logic          abort_s;
    logic          timeout_hit_s;

    assign any_valid_s = |req_valid;

    // Round-robin search starting just after the last requester served
    always_comb begin
        win_s      = {GW{1'b0}};
        win_data_s = 8'h00;
        found_s    = 1'b0;
        sum_s      = {(GW+1){1'b0}};
        idx_s      = {GW{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum_s = {1'b0, last_grant_r} + (GW+1)'(k);
            // wrap from NUM_REQ-1 back to 0 (handles non power-of-two NUM_REQ)
            if (sum_s >= (GW+1)'(NUM_REQ)) begin
                sum_s = sum_s - (GW+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[GW-1:0];
            if (!found_s && req_valid[idx_s]) begin
                found_s    = 1'b1;
                win_s      = idx_s;
                win_data_s = req_data[{idx_s, 3'b000} +: 8];
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Accept strobe: only the winner, only in IDLE, never under reset
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (rst && (state_r == IDLE) && any_valid_s) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt_r;
    logic          timeout_err_r;

    // Counter is 0 on the first WAIT cycle, so the abort lands TIMEOUT_CYCLES
    // cycles after WAIT entry
    assign timeout_hit_s = (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // WAIT-duration counter and abort pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r    <= {CW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= abort_s;
            if (state_r != WAIT) begin
                wait_cnt_r <= {CW{1'b0}};
            end else begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state and transfer/completion decode
    always_comb begin
        state_s    = state_r;
        transfer_s = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    transfer_s = 1'b1;
                    state_s    = SEND;
                end else begin
                    state_s    = IDLE;
                end
            end
            SEND: begin
                state_s = WAIT;
            end
            WAIT: begin
                // tx_done wins over a simultaneous timeout
                if (tx_done) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (timeout_hit_s) begin
                    abort_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_send_r    <= 1'b0;
            busy_r       <= 1'b0;
            tx_data_r    <= 8'h00;
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NUM_REQ - 1);
        end else begin
            tx_send_r <= transfer_s;
            busy_r    <= (state_s != IDLE);
            if (transfer_s) begin
                tx_data_r <= win_data_s;
                grant_r   <= win_s;
            end else begin
                tx_data_r <= tx_data_r;
                grant_r   <= grant_r;
            end
            if (done_s || abort_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign tx_send  = tx_send_r;
    assign tx_data  = tx_data_r;
    assign grant_id = grant_r;
    assign busy     = busy_r;

endmodule
